// File: rtl/count_one_fsm_scheduler_if.sv
// count_one_fsm_scheduler_if: request and result handshake bundle
// for the shared consecutive-ones detector.
interface count_one_fsm_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_bit;
  logic [NUM_CH-1:0] req_ready;
  logic [NUM_CH-1:0] ch_flush;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic              res_out;
  logic              res_ready;

  modport master (
    output req_valid,
    output req_bit,
    output ch_flush,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_ch,
    input  res_out
  );

  modport slave (
    input  req_valid,
    input  req_bit,
    input  ch_flush,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_ch,
    output res_out
  );
endinterface

// File: rtl/count_one_fsm_scheduler.sv
// count_one_fsm_scheduler: one consecutive-ones Mealy detector shared
// round-robin by NUM_CH streams. Option: COUNT_ONE_SCHED_HIT_CNT_EN.
module count_one_fsm_scheduler #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  count_one_fsm_scheduler_if.slave bus
`ifdef COUNT_ONE_SCHED_HIT_CNT_EN
  ,
  input  logic [NUM_CH-1:0]        cnt_clr,
  input  logic [CH_W-1:0]          cnt_sel,
  output logic [7:0]               cnt_value
`endif
);

  logic              stall;
  logic              acc;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_id;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] ctx_q, ctx_d;
  logic              ctx_eff;
  logic              hit;
  logic              res_valid_q, res_valid_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              res_out_q, res_out_d;

  assign stall         = res_valid_q & ~bus.res_ready;
  assign bus.req_ready = gnt;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_out   = res_out_q;

  // round-robin search from ptr upward; nothing granted while stalled
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    acc    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((32'(ptr_q) + 32'(k)) % 32'(NUM_CH));
      if (!acc && !stall && bus.req_valid[idx]) begin
        acc    = 1'b1;
        gnt_id = idx;
      end
    end
    if (acc) gnt[gnt_id] = 1'b1;
  end

  // pointer moves past the granted channel
  always_comb begin
    ptr_d = ptr_q;
    if (acc) begin
      ptr_d = (gnt_id == CH_W'(NUM_CH - 1)) ? '0
                                            : gnt_id + CH_W'(1);
    end
  end

  // detector state register: one context bit per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctx_q <= '0;
    else        ctx_q <= ctx_d;
  end

  // detector next state: flush clears, an accepted bit overrides
  always_comb begin
    ctx_d = ctx_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_flush[i]) ctx_d[i] = 1'b0;
    end
    if (acc) ctx_d[gnt_id] = bus.req_bit[gnt_id];
  end

  // detector Mealy output: same-cycle flush forces state0
  always_comb begin
    ctx_eff = bus.ch_flush[gnt_id] ? 1'b0 : ctx_q[gnt_id];
    hit     = acc & ctx_eff & bus.req_bit[gnt_id];
  end

  // result register: load on accept, clear on consume, hold on stall
  always_comb begin
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_out_d   = res_out_q;
    if (acc) begin
      res_valid_d = 1'b1;
      res_ch_d    = gnt_id;
      res_out_d   = hit;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // pointer and result flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_out_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_out_q   <= res_out_d;
    end
  end

`ifdef COUNT_ONE_SCHED_HIT_CNT_EN
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cnt_d [NUM_CH];

  // saturating hit counters; clear beats a same-cycle increment
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr[i]) begin
        cnt_d[i] = '0;
      end else if (hit && gnt_id == CH_W'(i)
                   && cnt_q[i] != 8'hff) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // counter flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_value = (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: doc/count_one_fsm_scheduler.md
# count_one_fsm_scheduler

Shares a single consecutive-ones Mealy detector between NUM_CH serial bit-stream requesters. Each channel keeps its own 1-bit detector context (state0 = last accepted bit 0, state1 = last accepted bit 1). A round-robin arbiter grants one channel per cycle and evaluates the accepted bit against that channel's saved context. The result is returned through a registered, back-pressured result port tagged with the channel id. The block sits between the bit-stream sources and downstream consumers of the per-channel "run of ones" flag.

## Interface
Parameters:
- NUM_CH, 4, number of requesters; legal range 2..16.
- CH_W, $clog2(NUM_CH), width of the channel id (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_CH  per-channel bit-valid.
- req_bit  input  NUM_CH  per-channel serial data bit.
- req_ready  output  NUM_CH  one-hot grant; combinational from req_valid, the round-robin pointer and the stall condition.
- ch_flush  input  NUM_CH  per-channel context reset to state0.
- res_valid  output  1  result valid.
- res_ch  output  CH_W  channel the result belongs to.
- res_out  output  1  detector output: 1 when the accepted bit and the channel's previous accepted bit are both 1.
- res_ready  input  1  downstream accepts the result.
- Only with COUNT_ONE_SCHED_HIT_CNT_EN:
  - cnt_clr  input  NUM_CH  per-channel counter clear.
  - cnt_sel  input  CH_W  read-select for the counter.
  - cnt_value  output  8  hit count of channel cnt_sel; combinational read.

## Operation
- Context: ctx[NUM_CH], 1 bit each. 0 = state0, 1 = state1.
- Stall: stall = res_valid & ~res_ready. While stall is asserted, req_ready is all zero and nothing is accepted.
- Arbitration: when stall is low, grant the first channel i with req_valid[i], searching from ptr upward modulo NUM_CH.
  - req_ready[i] = 1 for the granted channel only.
  - Accept = req_valid[i] & req_ready[i].
- Pointer:
  - On accept from channel i, ptr <= (i+1) mod NUM_CH.
  - With no accept, ptr holds its value.
- Evaluation on accept of bit b from channel i:
  - The effective context c is 0 if ch_flush[i] is asserted in the same cycle, otherwise ctx[i].
  - res_out <= c & b; res_ch <= i; res_valid <= 1; ctx[i] <= b.
- Flush without an accept on that channel: ctx[i] <= 0. Flushes on other channels are independent of the accept.
- Result register:
  - Loaded on accept.
  - If there is no accept and res_ready is high, res_valid <= 0.
  - While stalled, res_valid, res_ch and res_out are held stable.
- Reset values: res_valid 0, res_ch 0, res_out 0, all ctx 0, ptr 0, all counters 0.
- Reset asserted mid-stream discards the pending result and all contexts immediately.
- No state is retained for unaccepted requests. Requesters hold req_valid and req_bit until their req_ready is seen.

## Timing
- Latency: a bit accepted at edge N produces res_valid = 1 with its result after edge N.
- Throughput: one accept per cycle whenever res_ready is high, including in the same cycle the previous result is consumed.
- With all channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0.
- Worst-case wait for a continuously requesting channel: NUM_CH-1 grants to other channels.
- When res_ready drops, req_ready goes low in that same cycle. No accept is lost or duplicated.

## Configuration
- COUNT_ONE_SCHED_HIT_CNT_EN defined:
  - Adds an 8-bit counter per channel that increments when an accept produces res_out = 1.
  - Each counter saturates at 255.
  - cnt_clr[i] zeroes counter i; a clear in the same cycle as an increment wins, giving 0.
  - cnt_value shows the counter of channel cnt_sel.
- Not defined:
  - cnt_clr, cnt_sel and cnt_value are absent.
  - No counter storage exists.
  - All other behaviour is identical.

## Test plan
- Reset, then channel 0 sends bits 1,1,0,1,1,1 with res_ready = 1 -> res_out sequence 0,1,0,0,1,1, res_ch = 0 throughout, one result per cycle.
- All 4 channels valid continuously -> grants 0,1,2,3,0,1...; interleaving does not corrupt context: channel 2 sending all ones yields res_out 0 then 1 on every later result.
- Channel 1 in state1, ch_flush[1] asserted together with accepting bit 1 -> res_out = 0 and ctx[1] = 1; the next bit 1 gives res_out = 1.
- Hold res_ready = 0 for 3 cycles with channels requesting -> req_ready = 0, the result is held stable, ptr is unchanged, and flow resumes without loss when res_ready returns.
- Assert rst_n low while channel 3 is in state1 with a pending result -> res_valid = 0 immediately; after reset, bit 1 on channel 3 gives res_out = 0.
- With COUNT_ONE_SCHED_HIT_CNT_EN: 300 consecutive ones on channel 0 -> cnt_value = 255 with cnt_sel = 0; cnt_clr[0] together with a hit -> 0.
